spi_reg_master: RTL and testbench

SPI_REG_MASTER -- requirements
Module: spi_reg_master

---
 rtl/spi_reg_master.sv | 204 ++++++++++++++++++++
 tb/tb_spi_reg_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI controller for single register accesses.
// Each frame is {rw, addr, wdata}, sent MSB first. It supports all four CPOL/CPHA modes.
// SCLK half-period is CLK_DIV clk cycles. Every SPI output comes straight from a flop.
// Optional feature: define SPI_REG_MASTER_LOOPBACK_EN to add a 'loopback' input.
// When loopback is high, the controller samples its own MOSI in place of spi_miso.
module spi_reg_master #(
  parameter int CLK_DIV    = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int REG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic                  busy,
  output logic                  done,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
`ifdef SPI_REG_MASTER_LOOPBACK_EN
  ,
  input  logic                  loopback
`endif
);

  localparam int FRAME = 1 + ADDR_WIDTH + REG_WIDTH;
  localparam int HP_W  = $clog2(2 * FRAME);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             div_reg, div_next;
  logic [HP_W-1:0]        hp_reg, hp_next;
  logic                   cpol_reg, cpol_next;
  logic                   cpha_reg, cpha_next;
  logic                   rw_reg, rw_next;
  logic [FRAME-1:0]       tx_reg, tx_next;
  logic [REG_WIDTH-1:0]   rx_reg, rx_next;
  logic [REG_WIDTH-1:0]   rdata_reg, rdata_next;
  logic                   done_reg, done_next;
  logic                   cs_n_reg, cs_n_next;
  logic                   sclk_reg, sclk_next;
  logic                   mosi_reg, mosi_next;
  logic                   tick;
  logic                   edge_en;
  logic                   edge_lead;
  logic                   edge_last;
  logic                   miso_bit;

`ifdef SPI_REG_MASTER_LOOPBACK_EN
  assign miso_bit = loopback ? mosi_reg : spi_miso;
`else
  assign miso_bit = spi_miso;
`endif

  // Next-state, half-period timing and SPI output computation
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    hp_next    = hp_reg;
    cpol_next  = cpol_reg;
    cpha_next  = cpha_reg;
    rw_next    = rw_reg;
    tx_next    = tx_reg;
    rx_next    = rx_reg;
    rdata_next = rdata_reg;
    done_next  = 1'b0;
    cs_n_next  = cs_n_reg;
    sclk_next  = sclk_reg;
    mosi_next  = mosi_reg;
    edge_en    = 1'b0;
    edge_lead  = 1'b0;
    edge_last  = 1'b0;
    tick       = (div_reg == 8'(CLK_DIV - 1));

    if (state_reg != IDLE) begin
      div_next = tick ? 8'd0 : div_reg + 8'd1;
    end

    case (state_reg)
      IDLE: begin
        cs_n_next = 1'b1;
        sclk_next = cpol;
        mosi_next = 1'b0;
        if (start) begin
          state_next = SETUP;
          div_next   = 8'd0;
          hp_next    = '0;
          cpol_next  = cpol;
          cpha_next  = cpha;
          rw_next    = rw;
          tx_next    = {rw, addr, (rw ? wdata : {REG_WIDTH{1'b0}})};
          rx_next    = '0;
          cs_n_next  = 1'b0;
          // CPHA=0 needs the frame MSB (rw) on the wire before the first edge
          mosi_next  = cpha ? 1'b0 : rw;
        end
      end
      SETUP: begin
        if (tick) begin
          state_next = XFER;
          hp_next    = '0;
          edge_en    = 1'b1;
          edge_lead  = 1'b1;
        end
      end
      XFER: begin
        if (tick) begin
          if (hp_reg == HP_W'(2 * FRAME - 1)) begin
            state_next = HOLD;
            sclk_next  = cpol_reg;
          end else begin
            hp_next   = hp_reg + HP_W'(1);
            edge_en   = 1'b1;
            // Edge index is hp_reg+1, so an odd half-period ends with a leading edge
            edge_lead = hp_reg[0];
            edge_last = (hp_reg == HP_W'(2 * FRAME - 2));
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_next = GAP;
          hp_next    = '0;
          cs_n_next  = 1'b1;
          mosi_next  = 1'b0;
        end
      end
      GAP: begin
        if (tick) begin
          if (hp_reg == HP_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
            if (!rw_reg) begin
              rdata_next = rx_reg;
            end
          end else begin
            hp_next = hp_reg + HP_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // An SCLK edge either samples MISO or shifts MOSI, depending on mode
    if (edge_en) begin
      sclk_next = ~sclk_reg;
      if (edge_lead ^ cpha_reg) begin
        rx_next = (rx_reg << 1) | REG_WIDTH'(miso_bit);
      end else if (!edge_last) begin
        mosi_next = cpha_reg ? tx_reg[FRAME-1] : tx_reg[FRAME-2];
        tx_next   = tx_reg << 1;
      end
    end
  end

  // State register: async reset, frozen entirely while ena is low
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= IDLE;
      div_reg   <= 8'd0;
      hp_reg    <= '0;
      cpol_reg  <= 1'b0;
      cpha_reg  <= 1'b0;
      rw_reg    <= 1'b0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      rdata_reg <= '0;
      done_reg  <= 1'b0;
      cs_n_reg  <= 1'b1;
      sclk_reg  <= 1'b0;
      mosi_reg  <= 1'b0;
    end else if (ena) begin
      state_reg <= state_next;
      div_reg   <= div_next;
      hp_reg    <= hp_next;
      cpol_reg  <= cpol_next;
      cpha_reg  <= cpha_next;
      rw_reg    <= rw_next;
      tx_reg    <= tx_next;
      rx_reg    <= rx_next;
      rdata_reg <= rdata_next;
      done_reg  <= done_next;
      cs_n_reg  <= cs_n_next;
      sclk_reg  <= sclk_next;
      mosi_reg  <= mosi_next;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign rdata    = rdata_reg;
  assign spi_cs_n = cs_n_reg;
  assign spi_clk  = sclk_reg;
  assign spi_mosi = mosi_reg;

endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: directed tests for spi_reg_master.
// A cycle-sampled responder model captures MOSI and drives MISO from resp_frame.
module tb_spi_reg_master;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena = 1'b1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;
`ifdef SPI_REG_MASTER_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  // Responder / monitor state
  logic        mode_cpol = 1'b0;
  logic        mode_cpha = 1'b0;
  logic [15:0] resp_frame = 16'h0000;
  logic [15:0] mosi_bits = 16'h0000;
  int          edges = 0;
  int          cs_low_cycles = 0;
  int          done_cnt = 0;
  int          frame_cnt = 0;
  int          miso_idx = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        sclk_at_fall = 1'b0;
  logic        sclk_at_rise = 1'b0;

  spi_reg_master #(
    .CLK_DIV(8),
    .ADDR_WIDTH(7),
    .REG_WIDTH(8)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .ena(ena),
    .cpol(cpol),
    .cpha(cpha),
    .start(start),
    .rw(rw),
    .addr(addr),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .rdata(rdata),
    .spi_cs_n(spi_cs_n),
    .spi_clk(spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
`ifdef SPI_REG_MASTER_LOOPBACK_EN
    ,
    .loopback(loopback)
`endif
  );

  always #5 clk = ~clk;

  // Responder: samples/shifts on SCLK edges seen at the falling clk edge
  always @(negedge clk) begin : mon
    logic lead;
    if (prev_cs && !spi_cs_n) begin
      frame_cnt++;
      edges = 0;
      cs_low_cycles = 0;
      mosi_bits = 16'h0000;
      sclk_at_fall = spi_clk;
      miso_idx = 0;
      if (!mode_cpha) begin
        spi_miso = resp_frame[15];
        miso_idx = 1;
      end
    end else if (!spi_cs_n && (spi_clk !== prev_sclk)) begin
      edges++;
      lead = (spi_clk != mode_cpol);
      if (lead != mode_cpha) begin
        mosi_bits = {mosi_bits[14:0], spi_mosi};
      end else if (miso_idx < 16) begin
        spi_miso = resp_frame[15 - miso_idx];
        miso_idx++;
      end
    end
    if (!prev_cs && spi_cs_n) sclk_at_rise = spi_clk;
    if (!spi_cs_n) cs_low_cycles++;
    if (done) done_cnt++;
    prev_cs = spi_cs_n;
    prev_sclk = spi_clk;
  end

  task automatic do_start(input logic p, input logic h, input logic w,
                          input logic [6:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cpol = p; cpha = h; rw = w; addr = a; wdata = d; start = 1'b1;
    mode_cpol = p; mode_cpha = h;
    $display("txn mode=%0d rw=%0b addr=%h wdata=%h", {p, h}, w, a, d);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b expected 1", spi_cs_n); end
    total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b expected 0", spi_clk); end
    total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    rstb = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_mode0();
    bit ok;
    int d0;
    d0 = done_cnt;
    resp_frame = 16'h0000;
    do_start(1'b0, 1'b0, 1'b1, 7'h00, 8'hA5);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr0_busy_rise: got %b expected 1", busy); end
    wait_done(1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wr0_done_timeout: got %b expected 1", ok); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr0_busy_at_done: got %b expected 0", busy); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL wr0_rdata_kept: got %h expected 00", rdata); end
    repeat (20) @(negedge clk); #2;
    total++; if (mosi_bits !== 16'h80A5) begin bad++; $display("FAIL wr0_mosi: got %h expected 80a5", mosi_bits); end
    total++; if (edges != 32) begin bad++; $display("FAIL wr0_edges: got %0d expected 32", edges); end
    total++; if (cs_low_cycles != 272) begin bad++; $display("FAIL wr0_cs_low: got %0d expected 272", cs_low_cycles); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL wr0_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_read_modes();
    bit ok;
    logic [1:0] m;
    for (int i = 0; i < 4; i++) begin
      m = 2'(i);
      @(posedge clk); #1;
      cpol = m[1];
      repeat (2) @(negedge clk);
      total++; if (spi_clk !== m[1]) begin bad++; $display("FAIL rd%0d_idle_sclk: got %b expected %b", i, spi_clk, m[1]); end
      resp_frame = {8'h00, 8'hA5};
      do_start(m[1], m[0], 1'b0, 7'h06, 8'hFF);
      wait_done(1000, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL rd%0d_done_timeout: got %b expected 1", i, ok); end
      total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL rd%0d_rdata: got %h expected a5", i, rdata); end
      #2;
      total++; if (mosi_bits !== 16'h0600) begin bad++; $display("FAIL rd%0d_mosi: got %h expected 0600", i, mosi_bits); end
      total++; if (edges != 32) begin bad++; $display("FAIL rd%0d_edges: got %0d expected 32", i, edges); end
      total++; if (sclk_at_fall !== m[1]) begin bad++; $display("FAIL rd%0d_sclk_setup: got %b expected %b", i, sclk_at_fall, m[1]); end
      total++; if (sclk_at_rise !== m[1]) begin bad++; $display("FAIL rd%0d_sclk_hold: got %b expected %b", i, sclk_at_rise, m[1]); end
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int d0;
    int f0;
    d0 = done_cnt;
    f0 = frame_cnt;
    resp_frame = 16'h0000;
    do_start(1'b0, 1'b0, 1'b1, 7'h2B, 8'h96);
    repeat (100) @(posedge clk);
    #1;
    rw = 1'b1; addr = 7'h7F; wdata = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ign_done_timeout: got %b expected 1", ok); end
    #2;
    total++; if (mosi_bits !== 16'hAB96) begin bad++; $display("FAIL ign_mosi: got %h expected ab96", mosi_bits); end
    repeat (400) @(negedge clk); #2;
    total++; if (frame_cnt - f0 != 1) begin bad++; $display("FAIL ign_frames: got %0d expected 1", frame_cnt - f0); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL ign_dones: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bit reached;
    reached = 1'b0;
    resp_frame = 16'h0000;
    do_start(1'b1, 1'b1, 1'b1, 7'h12, 8'h77);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (edges >= 14) begin
        reached = 1'b1;
        break;
      end
    end
    total++; if (reached !== 1'b1) begin bad++; $display("FAIL rst_reach_bit7: got %b expected 1", reached); end
    #2 rstb = 1'b0;
    #1;
    total++; if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL rst_mid_cs_n: got %b expected 1", spi_cs_n); end
    total++; if (spi_clk !== 1'b0) begin bad++; $display("FAIL rst_mid_sclk: got %b expected 0", spi_clk); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    do_start(1'b0, 1'b0, 1'b1, 7'h21, 8'h3C);
    wait_done(1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_after_done_timeout: got %b expected 1", ok); end
    #2;
    total++; if (mosi_bits !== 16'hA13C) begin bad++; $display("FAIL rst_after_mosi: got %h expected a13c", mosi_bits); end
    total++; if (edges != 32) begin bad++; $display("FAIL rst_after_edges: got %0d expected 32", edges); end
    total++; if (cs_low_cycles != 272) begin bad++; $display("FAIL rst_after_cs_low: got %0d expected 272", cs_low_cycles); end
  endtask

  task automatic test_ena_freeze();
    bit ok;
    bit reached;
    bit changed;
    logic s;
    logic m;
    logic c;
    int e;
    reached = 1'b0;
    changed = 1'b0;
    resp_frame = {8'h00, 8'h3C};
    do_start(1'b0, 1'b1, 1'b0, 7'h33, 8'h00);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (edges >= 10) begin
        reached = 1'b1;
        break;
      end
    end
    total++; if (reached !== 1'b1) begin bad++; $display("FAIL ena_reach_xfer: got %b expected 1", reached); end
    @(posedge clk); #1;
    ena = 1'b0;
    s = spi_clk; m = spi_mosi; c = spi_cs_n;
    @(negedge clk); #1;
    e = edges;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (spi_clk !== s || spi_mosi !== m || spi_cs_n !== c) changed = 1'b1;
    end
    #2;
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL ena_frozen_pins: got %b expected 0", changed); end
    total++; if (edges != e) begin bad++; $display("FAIL ena_frozen_edges: got %0d expected %0d", edges, e); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ena_frozen_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    ena = 1'b1;
    wait_done(1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ena_done_timeout: got %b expected 1", ok); end
    total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL ena_rdata: got %h expected 3c", rdata); end
    #2;
    total++; if (mosi_bits !== 16'h3300) begin bad++; $display("FAIL ena_mosi: got %h expected 3300", mosi_bits); end
    total++; if (edges != 32) begin bad++; $display("FAIL ena_edges: got %0d expected 32", edges); end
  endtask

`ifdef SPI_REG_MASTER_LOOPBACK_EN
  task automatic test_loopback();
    bit ok;
    loopback = 1'b1;
    resp_frame = {8'h00, 8'hA5};
    do_start(1'b0, 1'b0, 1'b1, 7'h01, 8'h5A);
    wait_done(1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL lb_wr_done_timeout: got %b expected 1", ok); end
    total++; if (rdata !== 8'h3C) begin bad++; $display("FAIL lb_wr_rdata_kept: got %h expected 3c", rdata); end
    do_start(1'b0, 1'b0, 1'b0, 7'h01, 8'h00);
    wait_done(1000, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL lb_rd_done_timeout: got %b expected 1", ok); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL lb_rd_rdata: got %h expected 00", rdata); end
    loopback = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_mode0();
    test_read_modes();
    test_start_ignored();
    test_reset_midframe();
    test_ena_freeze();
`ifdef SPI_REG_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
